packet_injector: RTL and testbench

//  Host-to-switch ingress path: CPU writes bytes over the Avalon-MM slave into three per-port

---
 rtl/switch_pkg.sv | 20 ++
 rtl/inj_fifo.sv | 49 ++++
 rtl/packet_injector.sv | 156 +++++++++++++++
 tb/tb_packet_injector.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared register map, control/status bit positions and injector state encoding
// for the host-to-switch packet injector.
package switch_pkg;

    localparam logic [2:0] ADDR_CTRL = 3'b000;
    localparam logic [2:0] ADDR_Q1   = 3'b001;
    localparam logic [2:0] ADDR_Q2   = 3'b010;
    localparam logic [2:0] ADDR_Q3   = 3'b011;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    localparam int STAT_RUN   = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} inj_state_t;

endpackage

// File: rtl/inj_fifo.sv
// Synchronous byte FIFO with flush; full/empty are judged on the pre-edge count,
// so a push into a full queue is dropped even when a pop happens on the same edge.
module inj_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/packet_injector.sv
// Host-written per-port byte queues drained into switch input ports 1..3 as
// one-cycle (dataN, enN) strobes, with an optional forced idle gap per port.
module packet_injector
    import switch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       rdy1,
    input  logic       rdy2,
    input  logic       rdy3,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic       en1,
    output logic       en2,
    output logic       en3
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP + 2);

    logic          wr_ctrl;
    logic          flush;
    logic          clr_ovf;
    logic          run;
    logic [2:0]    ovf;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic [2:0]    full;
    logic [2:0]    empty;
    logic [2:0]    rdy;
    logic          en   [3];
    logic [7:0]    data [3];
    logic [7:0]    head [3];
    logic [CW-1:0] count [3];

    assign rdy     = {rdy3, rdy2, rdy1};
    assign wr_ctrl = chipselect && write && (address == ADDR_CTRL);
    assign flush   = wr_ctrl && writedata[CTRL_FLUSH];
    assign clr_ovf = wr_ctrl && writedata[CTRL_CLR_OVF];
    assign push[0] = chipselect && write && (address == ADDR_Q1);
    assign push[1] = chipselect && write && (address == ADDR_Q2);
    assign push[2] = chipselect && write && (address == ADDR_Q3);

    assign data1 = data[0];
    assign data2 = data[1];
    assign data3 = data[2];
    assign en1   = en[0];
    assign en2   = en[1];
    assign en3   = en[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            run <= 1'b0;
            ovf <= '0;
        end else begin
            if (wr_ctrl) run <= writedata[CTRL_RUN];
            if (clr_ovf) ovf <= '0;
            else         ovf <= ovf | (push & full);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'hFF;
        end else if (chipselect && read) begin
            case (address)
                ADDR_CTRL: readdata <= {1'b0, ovf, empty, run};
                ADDR_Q1:   readdata <= 8'(count[0]);
                ADDR_Q2:   readdata <= 8'(count[1]);
                ADDR_Q3:   readdata <= 8'(count[2]);
                default:   readdata <= 8'hFF;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_port
        inj_state_t    state;
        logic [GW-1:0] cnt;
        logic          can_pop;
        logic          en_r;
        logic [7:0]    data_r;

        inj_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .flush (flush),
            .wdata (writedata),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );

        // The last gap cycle doubles as the pop decision so strobes land GAP+1 apart.
        always_comb begin
            can_pop = 1'b0;
            case (state)
                IDLE:    can_pop = 1'b1;
                SEND:    can_pop = (GAP == 0);
                WAIT:    can_pop = (cnt == GW'(1));
                default: can_pop = 1'b0;
            endcase
        end

        assign pop[i]  = can_pop && run && !empty[i] && rdy[i] && !flush;
        assign en[i]   = en_r;
        assign data[i] = data_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                cnt    <= '0;
                en_r   <= 1'b0;
                data_r <= '0;
            end else if (flush) begin
                state <= IDLE;
                cnt   <= '0;
                en_r  <= 1'b0;
            end else if (pop[i]) begin
                state  <= SEND;
                en_r   <= 1'b1;
                data_r <= head[i];
            end else begin
                en_r <= 1'b0;
                case (state)
                    SEND: begin
                        if (GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT;
                            cnt   <= GW'(GAP);
                        end
                    end
                    WAIT: begin
                        if (cnt <= GW'(1)) state <= IDLE;
                        else               cnt   <= cnt - GW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Directed and randomized bench for packet_injector against a queue-and-timing
// reference model of the injector's register map and strobe rules.
module tb_packet_injector;

    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       rdy1, rdy2, rdy3;
    logic [7:0] data1, data2, data3;
    logic       en1, en2, en3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mq [3][$];
    logic       run_m;
    logic [2:0] ovf_m;
    int         next_ok [3];
    logic       en_exp [3];
    logic [7:0] data_exp [3];
    logic [7:0] rd_exp;

    logic [7:0] logq [3][$];
    int         logc [3][$];

    packet_injector #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .rdy1       (rdy1),
        .rdy2       (rdy2),
        .rdy3       (rdy3),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .en1        (en1),
        .en2        (en2),
        .en3        (en3)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk32(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {1'b0, ovf_m, mq[2].size() == 0, mq[1].size() == 0,
                          mq[0].size() == 0, run_m};
            3'd1: return 8'(mq[0].size());
            3'd2: return 8'(mq[1].size());
            3'd3: return 8'(mq[2].size());
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: advance the model from the pre-edge inputs, then compare outputs.
    task automatic step();
        logic wr, fl, clr;
        logic full_pre [3];
        logic rdy_a [3];
        int p;
        rdy_a = '{rdy1, rdy2, rdy3};
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                en_exp[k]   = 1'b0;
                data_exp[k] = 8'h00;
                next_ok[k]  = cyc + 1;
            end
            run_m  = 1'b0;
            ovf_m  = 3'b000;
            rd_exp = 8'hFF;
        end else begin
            wr  = chipselect && write;
            fl  = wr && address == 3'd0 && writedata[1];
            clr = wr && address == 3'd0 && writedata[2];
            if (chipselect && read) rd_exp = model_read(address);
            for (int k = 0; k < 3; k++) begin
                full_pre[k] = (mq[k].size() == DEPTH);
                en_exp[k] = run_m && mq[k].size() != 0 && rdy_a[k] && cyc >= next_ok[k] && !fl;
                if (en_exp[k]) begin
                    data_exp[k] = mq[k].pop_front();
                    next_ok[k]  = cyc + 1 + GAP;
                end
            end
            if (fl) begin
                for (int k = 0; k < 3; k++) begin
                    mq[k].delete();
                    next_ok[k] = cyc + 1;
                end
            end else if (wr && address >= 3'd1 && address <= 3'd3) begin
                p = int'(address) - 1;
                if (full_pre[p]) ovf_m[p] = 1'b1;
                else             mq[p].push_back(writedata);
            end
            if (wr && address == 3'd0) begin
                run_m = writedata[0];
                if (clr) ovf_m = 3'b000;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk8("en1", {7'b0, en1}, {7'b0, en_exp[0]});
        chk8("en2", {7'b0, en2}, {7'b0, en_exp[1]});
        chk8("en3", {7'b0, en3}, {7'b0, en_exp[2]});
        chk8("data1", data1, data_exp[0]);
        chk8("data2", data2, data_exp[1]);
        chk8("data3", data3, data_exp[2]);
        chk8("readdata", readdata, rd_exp);
        if (en1 === 1'b1) begin logq[0].push_back(data1); logc[0].push_back(cyc); end
        if (en2 === 1'b1) begin logq[1].push_back(data2); logc[1].push_back(cyc); end
        if (en3 === 1'b1) begin logq[2].push_back(data3); logc[2].push_back(cyc); end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
        v = readdata;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp2 [17];
        logic [7:0] exp1 [16];
        logic [7:0] exp3 [3];
        int base, nb, k;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; writedata = 8'h00; rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
        step();
        reset = 1'b0;

        // Reset state and idle outputs
        rd_reg(3'd0, v); chk8("status_after_reset", v, 8'h0E);
        rd_reg(3'd1, v); chk8("count1_after_reset", v, 8'h00);
        base = logq[0].size() + logq[1].size() + logq[2].size();
        repeat (20) step();
        chk32("no_strobes_idle", logq[0].size() + logq[1].size() + logq[2].size(), base);

        // Single byte latency
        rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
        wr_reg(3'd0, 8'h01);
        wr_reg(3'd1, 8'h01);
        step();
        chk8("latency_en1", {7'b0, en1}, 8'h01);
        chk8("latency_data1", data1, 8'h01);
        step();
        chk8("en1_one_cycle", {7'b0, en1}, 8'h00);
        rd_reg(3'd1, v); chk8("count1_drained", v, 8'h00);

        // Overflow on q2 and ordered drain
        wr_reg(3'd0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            exp2[i] = 8'($urandom);
            wr_reg(3'd2, exp2[i]);
        end
        rd_reg(3'd2, v); chk8("count2_full", v, 8'h10);
        rd_reg(3'd0, v); chk8("ovf2_set", {7'b0, v[5]}, 8'h01);
        base = logq[1].size();
        wr_reg(3'd0, 8'h01);
        repeat (60) step();
        chk32("q2_strobe_count", logq[1].size() - base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < logq[1].size()) chk8("q2_order", logq[1][base + i], exp2[i]);
        wr_reg(3'd0, 8'h05);
        rd_reg(3'd0, v); chk8("ovf2_cleared", {7'b0, v[5]}, 8'h00);

        // Gap spacing on port 3 and rdy back-pressure
        wr_reg(3'd0, 8'h00);
        for (int i = 0; i < 3; i++) wr_reg(3'd3, 8'hA0 + 8'(i));
        base = logc[2].size();
        wr_reg(3'd0, 8'h01);
        repeat (12) step();
        chk32("q3_strobe_count", logc[2].size() - base, 3);
        if (logc[2].size() >= base + 3) begin
            chk32("gap_1_2", logc[2][base + 1] - logc[2][base], GAP + 1);
            chk32("gap_2_3", logc[2][base + 2] - logc[2][base + 1], GAP + 1);
        end
        base = logq[2].size();
        for (int i = 0; i < 3; i++) begin
            exp3[i] = 8'($urandom);
            wr_reg(3'd3, exp3[i]);
        end
        step();
        rdy3 = 1'b0;
        nb = logq[2].size();
        repeat (5) step();
        chk32("no_strobe_rdy_low", logq[2].size(), nb);
        rdy3 = 1'b1;
        repeat (15) step();
        chk32("q3_no_loss", logq[2].size() - base, 3);
        for (int i = 0; i < 3; i++)
            if (base + i < logq[2].size()) chk8("q3_order", logq[2][base + i], exp3[i]);

        // Push into full q1 in the same cycle as a pop
        wr_reg(3'd0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            exp1[i] = 8'($urandom);
            wr_reg(3'd1, exp1[i]);
        end
        base = logq[0].size();
        wr_reg(3'd0, 8'h01);
        wr_reg(3'd1, 8'hEE);
        wr_reg(3'd0, 8'h00);
        rd_reg(3'd1, v); chk8("count1_after_full_pushpop", v, 8'h0F);
        rd_reg(3'd0, v); chk8("ovf1_set", {7'b0, v[4]}, 8'h01);
        wr_reg(3'd0, 8'h01);
        repeat (60) step();
        chk32("q1_strobe_count", logq[0].size() - base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < logq[0].size()) chk8("q1_order", logq[0][base + i], exp1[i]);
        wr_reg(3'd0, 8'h04);

        // Flush with q1/q2 loaded and q3 mid-gap
        rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_reg(3'd1, 8'($urandom));
            wr_reg(3'd2, 8'($urandom));
        end
        wr_reg(3'd3, 8'h5A);
        wr_reg(3'd0, 8'h01);
        k = 0;
        while (k < 10 && en3 !== 1'b1) begin
            step();
            k++;
        end
        chk8("q3_strobe_before_flush", {7'b0, en3}, 8'h01);
        step();
        rdy1 = 1'b1; rdy2 = 1'b1;
        wr_reg(3'd0, 8'h03);
        chk8("flush_en", {5'b0, en3, en2, en1}, 8'h00);
        rd_reg(3'd1, v); chk8("flush_count1", v, 8'h00);
        rd_reg(3'd2, v); chk8("flush_count2", v, 8'h00);
        rd_reg(3'd3, v); chk8("flush_count3", v, 8'h00);
        rd_reg(3'd0, v); chk8("flush_run_kept", v, 8'h0F);

        // Reset asserted during a strobe
        wr_reg(3'd1, 8'hC3);
        step();
        chk8("send_before_reset", {7'b0, en1}, 8'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk8("reset_en1", {7'b0, en1}, 8'h00);
        chk8("reset_data1", data1, 8'h00);
        chk8("reset_readdata", readdata, 8'hFF);
        rd_reg(3'd0, v); chk8("status_after_midreset", v, 8'h0E);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 99);
            rdy1 = ($urandom_range(0, 3) != 0);
            rdy2 = ($urandom_range(0, 3) != 0);
            rdy3 = ($urandom_range(0, 3) != 0);
            chipselect = 1'b0; write = 1'b0; read = 1'b0;
            if (r < 45) begin
                chipselect = 1'b1; write = 1'b1;
                address = 3'($urandom_range(1, 3));
                writedata = 8'($urandom);
            end else if (r < 50) begin
                chipselect = 1'b1; write = 1'b1;
                address = 3'd0;
                writedata = {5'b0, ($urandom_range(0, 3) == 0),
                             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)};
            end else if (r < 53) begin
                chipselect = 1'b1; write = 1'b1;
                address = 3'($urandom_range(4, 7));
                writedata = 8'($urandom);
            end else if (r < 75) begin
                chipselect = 1'b1; read = 1'b1;
                address = 3'($urandom_range(0, 7));
            end
            step();
        end
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
